mem_access_seq: RTL and testbench

//  Parametrised memory-access sequencer for the MEM stage; next generation of the LDI/STI pointer FSM.

---
 rtl/mem_access_seq.sv | 179 +++++++++++++++++
 tb/tb_mem_access_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: MEM-stage memory-access sequencer.
// Takes one request, follows 0..MAX_IND pointer levels through the data
// cache, then performs one word/byte load or store and returns one result.
module mem_access_seq #(
  parameter  int DATA_W  = 16,
  parameter  int ADDR_W  = 16,
  parameter  int MAX_IND = 2,
  localparam int LVL_W   = $clog2(MAX_IND + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [LVL_W-1:0]      req_levels,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [ADDR_W-1:0]     rsp_addr,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_ACCESS, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_LDW  = 3'b000,
    OP_LDBZ = 3'b001,
    OP_LDBS = 3'b010,
    OP_STW  = 3'b011,
    OP_STB  = 3'b100
  } op_e;

  state_e              r_state;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;
  logic [LVL_W-1:0]    r_lvl;
  logic                r_err;

  logic                w_req_illegal;
  logic                w_req_over;
  logic [LVL_W-1:0]    w_req_lvl;
  logic [ADDR_W-1:0]   w_word_addr;
  logic [LB-1:0]       w_lane;
  logic [7:0]          w_byte;
  logic [NB-1:0]       w_lane_mask;
  logic [DATA_W-1:0]   w_load_data;

  // Request decode: illegal opcode and level clamping
  always_comb begin
    w_req_illegal = (req_op > 3'b100);
    w_req_over    = (req_levels > LVL_W'(MAX_IND));
    w_req_lvl     = w_req_over ? LVL_W'(MAX_IND) : req_levels;
  end

  // Address, lane and load-extension helpers derived from the current pointer
  always_comb begin
    w_word_addr = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
    w_lane      = r_addr[LB-1:0];
    w_byte      = mem_rdata[{w_lane, 3'b000} +: 8];
    w_lane_mask = {{(NB-1){1'b0}}, 1'b1} << w_lane;
    case (r_op)
      OP_LDBZ: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LDBS: w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Sequencer FSM: accept, chase pointers, access, report
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_LDW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_lvl   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_data  <= '0;
            if (w_req_illegal) begin
              r_op    <= OP_LDW;
              r_lvl   <= '0;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_op    <= op_e'(req_op);
              r_lvl   <= w_req_lvl;
              r_err   <= w_req_over;
              r_state <= (w_req_lvl != '0) ? S_PTR : S_ACCESS;
            end
          end
        end
        S_PTR: begin
          if (mem_resp) begin
            r_addr <= mem_rdata;
            r_lvl  <= r_lvl - LVL_W'(1);
            if (r_lvl == LVL_W'(1)) r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_resp) begin
            if (r_op == OP_LDW || r_op == OP_LDBZ || r_op == OP_LDBS)
              r_data <= w_load_data;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Cache port and response outputs, decoded from registered state only,
  // so an asynchronous reset drops the strobes in the same cycle
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    case (r_state)
      S_PTR: begin
        mem_read    = 1'b1;
        mem_address = w_word_addr;
      end
      S_ACCESS: begin
        case (r_op)
          OP_LDW: begin
            mem_read    = 1'b1;
            mem_address = w_word_addr;
          end
          OP_LDBZ, OP_LDBS: begin
            mem_read    = 1'b1;
            mem_address = r_addr;
          end
          OP_STW: begin
            mem_write   = 1'b1;
            mem_address = w_word_addr;
            mem_wmask   = '1;
            mem_wdata   = r_wdata;
          end
          OP_STB: begin
            mem_write   = 1'b1;
            mem_address = r_addr;
            mem_wmask   = w_lane_mask;
            mem_wdata   = {NB{r_wdata[7:0]}};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    req_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_DONE);
    rsp_data  = r_data;
    rsp_addr  = r_addr;
    rsp_err   = r_err;
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Testbench for mem_access_seq: directed cases followed by randomized
// requests against a pointer-chasing reference model and a cache responder
// with random wait states.
module tb_mem_access_seq;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MI = 2;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [LW-1:0] req_levels = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_wmask;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          busy;

  mem_access_seq #(.DATA_W(DW), .ADDR_W(AW), .MAX_IND(MI)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_levels(req_levels), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Word-organised backing memory, indexed by address >> 1
  logic [15:0] mem [0:32767];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  mask;
    logic [15:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  acc_t cur_acc;
  acc_t popped;

  int wait_lo = 0;
  int wait_hi = 0;
  int waits_acc = 0;
  int acc_count = 0;
  logic in_acc = 1'b0;
  int cnt = 0;
  int target = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cache responder: checks each access against the expected queue,
  // holds strobes under scrutiny while waiting, answers after a random delay
  always @(negedge clk) begin
    if (reset) begin
      in_acc    = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
    end else begin
      chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_read || mem_write) begin
        if (!in_acc) begin
          in_acc  = 1'b1;
          cnt     = 0;
          target  = $urandom_range(wait_hi, wait_lo);
          acc_count++;
          cur_acc.wr    = mem_write;
          cur_acc.addr  = mem_address;
          cur_acc.mask  = mem_wmask;
          cur_acc.wdata = mem_wdata;
          if (exp_q.size() == 0) begin
            chk("unexpected_access", {31'b0, mem_write}, 32'hFFFF_FFFF);
          end else begin
            popped = exp_q.pop_front();
            chk("acc_kind", {31'b0, mem_write}, {31'b0, popped.wr});
            chk("acc_addr", {16'b0, mem_address}, {16'b0, popped.addr});
            if (popped.wr) begin
              chk("acc_wmask", {30'b0, mem_wmask}, {30'b0, popped.mask});
              chk("acc_wdata", {16'b0, mem_wdata}, {16'b0, popped.wdata});
            end
          end
        end else begin
          chk("strobe_hold",
              {mem_write, mem_read, 10'b0, mem_wmask, mem_address},
              {cur_acc.wr, ~cur_acc.wr, 10'b0, cur_acc.mask, cur_acc.addr});
        end
        if (cnt == target) begin
          mem_resp  = 1'b1;
          mem_rdata = mem[mem_address[15:1]];
          if (mem_write) begin
            if (mem_wmask[0]) mem[mem_address[15:1]][7:0]  = mem_wdata[7:0];
            if (mem_wmask[1]) mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
          end
          in_acc    = 1'b0;
          waits_acc = waits_acc + target;
        end else begin
          cnt++;
          mem_resp  = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        in_acc    = 1'b0;
        mem_resp  = 1'($urandom);
        mem_rdata = 16'($urandom);
      end
    end
  end

  function automatic acc_t mk_acc(input logic wr, input logic [15:0] a,
                                  input logic [1:0] m, input logic [15:0] d);
    acc_t t;
    t.wr = wr; t.addr = a; t.mask = m; t.wdata = d;
    return t;
  endfunction

  // Issue one request (called at a negedge with the DUT idle) and check the
  // response against the reference model
  task automatic run_req(input logic [2:0] op, input int lvl,
                         input logic [15:0] addr, input logic [15:0] wd);
    logic [15:0] a, w, ed;
    logic [7:0]  b;
    logic        err;
    int          L, lat, exp_lat;
    err = (op > 3'd4) || (lvl > MI);
    a   = addr;
    ed  = 16'h0;
    L   = 0;
    if (op <= 3'd4) begin
      L = (lvl > MI) ? MI : lvl;
      for (int i = 0; i < L; i++) begin
        exp_q.push_back(mk_acc(1'b0, a & 16'hFFFE, 2'b00, 16'h0));
        a = mem[a >> 1];
      end
      w = mem[a >> 1];
      b = 8'(w >> (8 * a[0]));
      case (op)
        3'd0: begin ed = w;               exp_q.push_back(mk_acc(1'b0, a & 16'hFFFE, 2'b00, 16'h0)); end
        3'd1: begin ed = {8'h00, b};      exp_q.push_back(mk_acc(1'b0, a, 2'b00, 16'h0)); end
        3'd2: begin ed = {{8{b[7]}}, b};  exp_q.push_back(mk_acc(1'b0, a, 2'b00, 16'h0)); end
        3'd3: begin ed = 16'h0;           exp_q.push_back(mk_acc(1'b1, a & 16'hFFFE, 2'b11, wd)); end
        default: begin
          ed = 16'h0;
          exp_q.push_back(mk_acc(1'b1, a, a[0] ? 2'b10 : 2'b01, {wd[7:0], wd[7:0]}));
        end
      endcase
      exp_lat = 2 + L;
    end else begin
      exp_lat = 1;
    end

    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    waits_acc  = 0;
    acc_count  = 0;
    req_valid  = 1'b1;
    req_op     = op;
    req_levels = LW'(lvl);
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_op     = 3'($urandom);
    req_levels = LW'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat >= 200) break;
      @(posedge clk);
      lat++;
    end
    chk("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_data", {16'b0, rsp_data}, {16'b0, ed});
    chk("rsp_addr", {16'b0, rsp_addr}, {16'b0, a});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    chk("latency", lat - waits_acc, exp_lat);
    chk("acc_count", acc_count, (op > 3'd4) ? 0 : L + 1);
    chk("acc_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("rsp_pulse_once", {31'b0, rsp_valid}, 32'd0);
    chk("idle_after_done", {30'b0, busy, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

    // Reset state
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_busy_rsp", {30'b0, busy, rsp_valid}, 32'd0);
    chk("rst_outputs", {rsp_data, rsp_addr}, 32'd0);
    chk("rst_mem_port", {mem_address, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Word load, lvl0, zero-wait
    wait_lo = 0; wait_hi = 0;
    mem[16'h1002 >> 1] = 16'hBEEF;
    run_req(3'd0, 0, 16'h1003, 16'h0);

    // Byte loads, sign- and zero-extended
    mem[16'h2000 >> 1] = 16'h80AA;
    run_req(3'd2, 0, 16'h2001, 16'h0);
    run_req(3'd1, 0, 16'h2001, 16'h0);

    // Byte store, lane 0
    run_req(3'd4, 0, 16'h3000, 16'h1234);
    chk("stb_mem", {16'b0, mem[16'h3000 >> 1][7:0]}, 32'h34);

    // Two-level chase, every access waiting 3 cycles
    wait_lo = 3; wait_hi = 3;
    mem[16'h4000 >> 1] = 16'h5000;
    mem[16'h5000 >> 1] = 16'h6000;
    mem[16'h6000 >> 1] = 16'h7777;
    run_req(3'd0, 2, 16'h4000, 16'h0);

    // Illegal op and over-deep level request
    wait_lo = 0; wait_hi = 1;
    run_req(3'd6, 0, 16'h1234, 16'h0);
    run_req(3'd7, 1, 16'h4000, 16'h0);
    run_req(3'd0, 3, 16'h4000, 16'h0);
    run_req(3'd3, 1, 16'h4001, 16'hA5C3);

    // Randomized back-to-back requests
    for (int i = 0; i < 120; i++) begin
      wait_lo = 0;
      wait_hi = $urandom_range(2, 0);
      rv = $urandom_range(9, 0);
      run_req((rv == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0)),
              $urandom_range(3, 0), 16'($urandom), 16'($urandom));
    end

    // Reset while stalled in a pointer read
    wait_lo = 40; wait_hi = 40;
    exp_q.push_back(mk_acc(1'b0, 16'h4000, 2'b00, 16'h0));
    req_valid  = 1'b1;
    req_op     = 3'd0;
    req_levels = LW'(1);
    req_addr   = 16'h4001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("ptr_stall_read", {31'b0, mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("abort_ready", {30'b0, busy, req_ready}, 32'd1);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    wait_lo = 0; wait_hi = 0;
    rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    chk("abort_no_rsp", rv, 0);
    chk("abort_idle_ready", {31'b0, req_ready}, 32'd1);
    run_req(3'd0, 0, 16'h1002, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
